// File: rtl/seq_scan_if.sv
// Stream-in / report-out bundle for the serial pattern scan controller.
interface seq_scan_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PAT_W  = 4,
    parameter int unsigned CNT_W  = 8
);
    logic [PAT_W-1:0]  cfg_pattern;
    logic              cfg_overlap;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              match_pulse;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;

    // Word source / report consumer side
    modport master (
        output cfg_pattern, cfg_overlap, in_valid, in_data, in_last, out_ready,
        input  in_ready, match_pulse, out_valid, out_count
    );

    // Controller side
    modport slave (
        input  cfg_pattern, cfg_overlap, in_valid, in_data, in_last, out_ready,
        output in_ready, match_pulse, out_valid, out_count
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Frame-oriented serial pattern detector: serialises words MSB-first through a
// history register, pulses on each match and reports a saturating per-frame
// match count at frame end.
module seq_scan_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PAT_W  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    seq_scan_if.slave  bus
);

    localparam int unsigned BC_W   = $clog2(DATA_W);
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [BC_W-1:0]   LAST_BIT  = BC_W'(DATA_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   shreg_q;
    logic                last_q;
    logic [BC_W-1:0]     bitcnt_q;
    logic [PAT_W-1:0]    hist_q;
    logic [PAT_W-1:0]    hist_d;
    logic [FILL_W-1:0]   fill_q;
    logic [FILL_W-1:0]   fill_inc;
    logic [FILL_W-1:0]   fill_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                hit;
    logic                frame_active_q;
    logic [PAT_W-1:0]    pat_q;
    logic                ovl_q;
    logic                match_pulse_q;
    logic                out_valid_q;
    logic [CNT_W-1:0]    out_count_q;

    // Ready is a pure decode of the state register so it is glitch-free.
    assign bus.in_ready    = (state_q == ST_IDLE);
    assign bus.match_pulse = match_pulse_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_count   = out_count_q;

    // History/fill/count values after shifting in the current serial bit.
    always_comb begin
        hist_d   = {hist_q[PAT_W-2:0], shreg_q[DATA_W-1]};
        fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        hit      = (fill_inc == FILL_FULL) && (hist_d == pat_q);
        fill_d   = (hit && !ovl_q) ? '0 : fill_inc;
        cnt_d    = (hit && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Controller FSM with its datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            shreg_q        <= '0;
            last_q         <= 1'b0;
            bitcnt_q       <= '0;
            hist_q         <= '0;
            fill_q         <= '0;
            cnt_q          <= '0;
            frame_active_q <= 1'b0;
            pat_q          <= '0;
            ovl_q          <= 1'b0;
            match_pulse_q  <= 1'b0;
            out_valid_q    <= 1'b0;
            out_count_q    <= '0;
        end else begin
            match_pulse_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        shreg_q  <= bus.in_data;
                        last_q   <= bus.in_last;
                        bitcnt_q <= '0;
                        // Configuration is frozen for the whole frame.
                        if (!frame_active_q) begin
                            pat_q          <= bus.cfg_pattern;
                            ovl_q          <= bus.cfg_overlap;
                            frame_active_q <= 1'b1;
                        end
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    shreg_q       <= {shreg_q[DATA_W-2:0], 1'b0};
                    bitcnt_q      <= bitcnt_q + BC_W'(1);
                    hist_q        <= hist_d;
                    fill_q        <= fill_d;
                    cnt_q         <= cnt_d;
                    match_pulse_q <= hit;
                    if (bitcnt_q == LAST_BIT) begin
                        if (last_q) begin
                            // Count includes a match on the final bit.
                            out_count_q <= cnt_d;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_REPORT;
                        end else begin
                            // History persists so matches may span words.
                            state_q <= ST_IDLE;
                        end
                    end
                end

                ST_REPORT: begin
                    if (bus.out_ready) begin
                        out_valid_q    <= 1'b0;
                        cnt_q          <= '0;
                        hist_q         <= '0;
                        fill_q         <= '0;
                        frame_active_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Randomised self-checking bench for seq_scan_ctrl; two instances (8-bit and
// 3-bit counters) share stimulus and are checked against a bit-queue model.
module tb_seq_scan_ctrl;

    typedef logic [7:0] word_q_t[$];

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    seq_scan_if #(.DATA_W(8), .PAT_W(4), .CNT_W(8)) bus8 ();
    seq_scan_if #(.DATA_W(8), .PAT_W(4), .CNT_W(3)) bus3 ();

    assign bus3.cfg_pattern = bus8.cfg_pattern;
    assign bus3.cfg_overlap = bus8.cfg_overlap;
    assign bus3.in_valid    = bus8.in_valid;
    assign bus3.in_data     = bus8.in_data;
    assign bus3.in_last     = bus8.in_last;
    assign bus3.out_ready   = bus8.out_ready;

    seq_scan_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8.slave)
    );

    seq_scan_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(3)) dut_s (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},  32'(bus8.in_ready), 32'd1);
        check({tag, "_mp"},   32'(bus8.match_pulse), 32'd0);
        check({tag, "_ov"},   32'(bus8.out_valid), 32'd0);
        check({tag, "_oc"},   32'(bus8.out_count), 32'd0);
        check({tag, "_ov3"},  32'(bus3.out_valid), 32'd0);
        check({tag, "_oc3"},  32'(bus3.out_count), 32'd0);
    endtask

    // Drive one frame and check every bit-cycle pulse plus the final report.
    // Called and returns at posedge+1.
    task automatic run_frame(input logic [3:0] pat, input logic ovl, input word_q_t words,
                             input int bp, output logic [7:0] got8, output logic [2:0] got3);
        bit        hq[$];
        int        cnt;
        bit        exp_p;
        logic [3:0] v;
        int        gap;
        logic [7:0] exp8;
        logic [2:0] exp3;
        logic [7:0] held8;
        cnt = 0;
        for (int k = 0; k < words.size(); k++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                bus8.in_valid  = 1'b0;
                bus8.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                check("idle_rdy", 32'(bus8.in_ready), 32'd1);
                check("idle_ov",  32'(bus8.out_valid), 32'd0);
            end
            if (k == 0) begin
                bus8.cfg_pattern = pat;
                bus8.cfg_overlap = ovl;
            end else begin
                bus8.cfg_pattern = 4'($urandom);
                bus8.cfg_overlap = 1'($urandom);
            end
            bus8.in_valid = 1'b1;
            bus8.in_data  = words[k];
            bus8.in_last  = (k == words.size() - 1);
            check("acc_rdy", 32'(bus8.in_ready), 32'd1);
            @(posedge clk); #1;
            bus8.cfg_pattern = 4'($urandom);
            bus8.cfg_overlap = 1'($urandom);
            for (int b = 0; b < 8; b++) begin
                check("shift_rdy", 32'(bus8.in_ready), 32'd0);
                bus8.in_valid  = (b < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus8.in_data   = 8'($urandom);
                bus8.in_last   = 1'($urandom);
                bus8.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                hq.push_back(words[k][7-b]);
                if (hq.size() > 4) void'(hq.pop_front());
                exp_p = 1'b0;
                if (hq.size() == 4) begin
                    v = '0;
                    foreach (hq[i]) v = {v[2:0], hq[i]};
                    if (v == pat) begin
                        exp_p = 1'b1;
                        cnt++;
                        if (!ovl) hq.delete();
                    end
                end
                check("pulse8", 32'(bus8.match_pulse), 32'(exp_p));
                check("pulse3", 32'(bus3.match_pulse), 32'(exp_p));
            end
            if (k != words.size() - 1) begin
                check("word_end_rdy", 32'(bus8.in_ready), 32'd1);
                check("word_end_ov",  32'(bus8.out_valid), 32'd0);
            end
        end
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b0;
        exp8 = (cnt > 255) ? 8'd255 : 8'(cnt);
        exp3 = (cnt > 7)   ? 3'd7   : 3'(cnt);
        check("rep_ov8", 32'(bus8.out_valid), 32'd1);
        check("rep_ov3", 32'(bus3.out_valid), 32'd1);
        check("rep_cnt8", 32'(bus8.out_count), 32'(exp8));
        check("rep_cnt3", 32'(bus3.out_count), 32'(exp3));
        held8 = exp8;
        for (int c = 0; c < bp; c++) begin
            bus8.in_valid = 1'($urandom_range(0, 1));
            bus8.in_data  = 8'($urandom);
            @(posedge clk); #1;
            check("bp_ov",   32'(bus8.out_valid), 32'd1);
            check("bp_cnt",  32'(bus8.out_count), 32'(held8));
            check("bp_cnt3", 32'(bus3.out_count), 32'(exp3));
            check("bp_rdy",  32'(bus8.in_ready), 32'd0);
        end
        got8 = bus8.out_count;
        got3 = bus3.out_count;
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        check("post_ov",  32'(bus8.out_valid), 32'd0);
        check("post_ov3", 32'(bus3.out_valid), 32'd0);
        check("post_rdy", 32'(bus8.in_ready), 32'd1);
    endtask

    word_q_t    wq;
    logic [7:0] g8;
    logic [2:0] g3;

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus8.cfg_pattern = '0;
        bus8.cfg_overlap = 1'b0;
        bus8.in_valid    = 1'b0;
        bus8.in_data     = '0;
        bus8.in_last     = 1'b0;
        bus8.out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        wq = {8'hB6};
        run_frame(4'hB, 1'b1, wq, 0, g8, g3);
        check("b6_ovl", 32'(g8), 32'd2);
        run_frame(4'hB, 1'b0, wq, 1, g8, g3);
        check("b6_novl", 32'(g8), 32'd1);

        wq = {8'h01, 8'h60};
        run_frame(4'hB, 1'b1, wq, 10, g8, g3);
        check("span", 32'(g8), 32'd1);
        wq = {8'h01};
        run_frame(4'hB, 1'b1, wq, 0, g8, g3);
        check("split_a", 32'(g8), 32'd0);
        wq = {8'h60};
        run_frame(4'hB, 1'b1, wq, 0, g8, g3);
        check("split_b", 32'(g8), 32'd0);

        wq = {8'h00, 8'h00, 8'h00};
        run_frame(4'h0, 1'b1, wq, 2, g8, g3);
        check("zeros8", 32'(g8), 32'd21);
        check("zeros3", 32'(g3), 32'd7);

        // Asynchronous reset between clock edges in the middle of a word.
        bus8.cfg_pattern = 4'hB;
        bus8.cfg_overlap = 1'b1;
        bus8.in_valid    = 1'b1;
        bus8.in_data     = 8'hB6;
        bus8.in_last     = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("arst_rel");
        wq = {8'hB6};
        run_frame(4'hB, 1'b1, wq, 0, g8, g3);
        check("after_rst", 32'(g8), 32'd2);

        for (int n = 0; n < 40; n++) begin
            int nw;
            nw = int'($urandom_range(1, 4));
            wq = {};
            for (int k = 0; k < nw; k++) wq.push_back(8'($urandom));
            run_frame(4'($urandom), 1'($urandom), wq, int'($urandom_range(0, 3)), g8, g3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
